spi_mode0_slave: RTL and testbench
==================================

// Module: spi_mode0_slave
// PURPOSE
//  SPI mode 0 (CPOL=0, CPHA=0) responder. It is the peripheral-side counterpart of the team's
//  SPI mode 0 master, used to emulate PmodJSTK-style slaves in loopback and on board.
//  SS, SCLK and MOSI are oversampled and edge-detected on the fast system clock CLK.
//  Full duplex, MSB first: each byte clocks in a received byte and clocks out TX_DIN.
//  A byte-level handshake faces the user logic.
// PARAMETERS
//  DATA_W       8   bits per byte/word shifted per transfer unit
//  SYNC_STAGES  2   flip-flop synchronizer depth on SS, SCLK and MOSI (>=2)
// PORTS
//  CLK        in   1       system clock; all logic on posedge CLK
//  RST        in   1       synchronous, active-high reset
//  SS         in   1       slave select from master, active low (asynchronous)
//  SCLK       in   1       serial clock from master (asynchronous, idle low)
//  MOSI       in   1       master out slave in (asynchronous)
//  MISO       out  1       slave out; tx_sr MSB while selected, else 0
//  MISO_OE    out  1       1 = drive MISO pin; 0 = tristate (SS high)
//  TX_DIN     in   DATA_W  next byte to transmit; sampled on TX_ACK cycle
//  TX_ACK     out  1       1-cycle pulse: TX_DIN captured into tx_sr
//  RX_DOUT    out  DATA_W  last complete received byte; holds until next completes
//  RX_VALID   out  1       1-cycle pulse: RX_DOUT updated
//  BUSY       out  1       1 while synchronized SS is low (frame active)
//  FRAME_ERR  out  1       1-cycle pulse: SS rose with 1..DATA_W-1 bits of a byte received
// BEHAVIOUR
//  Reset
//  - All outputs 0. tx_sr, rx_sr, bit_cnt = 0. FSM = IDLE.
//  - Synchronizer chains for SS reset to 1; SCLK and MOSI chains reset to 0.
//  - A frame never starts from an SS that is already low at reset release. SS must be seen high,
//    then falling.
//  Edge detection
//  - ss_fall, ss_rise, sck_rise, sck_fall come from the last synchronizer stage versus a 1-cycle
//    delayed copy.
//  - Input-to-detect latency is SYNC_STAGES+1 CLK.
//  - Timing rule: SCLK high and low phases >= SYNC_STAGES+3 CLK periods.
//  - Timing rule: SS fall to first SCLK rise >= SYNC_STAGES+3 CLK periods.
//  FSM states
//  - IDLE: MISO_OE=0, BUSY=0. On ss_fall -> LOAD.
//  - LOAD (1 cycle): tx_sr<=TX_DIN, TX_ACK=1, bit_cnt<=0, MISO_OE=1, BUSY=1 -> SHIFT.
//  - SHIFT, on sck_rise: rx_sr<={rx_sr[DATA_W-2:0],MOSI_sync}; bit_cnt++.
//  - SHIFT, on bit_cnt reaching DATA_W at that rise:
//    - RX_DOUT<=completed byte; RX_VALID pulses the next cycle.
//    - bit_cnt<=0; set flag byte_done.
//  - SHIFT, on sck_fall:
//    - If byte_done: tx_sr<=TX_DIN, TX_ACK=1, clear byte_done. This starts the next byte of a
//      multi-byte frame.
//    - Else if bit_cnt!=0: tx_sr<=tx_sr<<1 (zero fill).
//    - A sck_fall with bit_cnt==0 and no byte_done is ignored.
//  - Any state, on ss_rise: go to IDLE the same cycle; MISO_OE<=0; BUSY<=0; bit_cnt<=0.
//    - Pulse FRAME_ERR if bit_cnt was 1..DATA_W-1.
//    - The partial rx byte is discarded; RX_DOUT keeps its previous value.
//  Simultaneous events
//  - ss_rise and an SCLK edge in the same cycle: ss_rise wins and the edge is ignored.
//  - sck_rise completing a byte and ss_rise together: the byte is still delivered (RX_VALID), no
//    FRAME_ERR.
//  Other rules
//  - SCLK edges while in IDLE or with SS high are ignored. MOSI is don't-care outside SHIFT.
//  - RST asserted mid-frame: immediate return to reset state.
//    - No RX_VALID and no FRAME_ERR for the aborted byte.
//    - The slave stays idle until SS is seen high again.
//  - MISO = MISO_OE ? tx_sr[DATA_W-1] : 0. It is registered, with no combinational path from
//    the pins.
// TESTING
//  1. Master sends 0xA5, TX_DIN=0x3C:
//     - 1 TX_ACK; MISO bits 0,0,1,1,1,1,0,0.
//     - RX_VALID once, RX_DOUT=0xA5; BUSY falls after SS rises.
//  2. 5-byte frame (PmodJSTK style), MOSI 0x81,0,0,0,0, TX_DIN updated after each TX_ACK to
//     0x10..0x14:
//     - 5 TX_ACK, 5 RX_VALID; master reads 10 11 12 13 14.
//  3. SS low, 3 SCLK cycles, SS high:
//     - FRAME_ERR pulses once; no RX_VALID; RX_DOUT unchanged.
//     - The next full frame of 0x5A is received correctly.
//  4. SCLK toggles 16 times with SS high:
//     - No TX_ACK, RX_VALID or FRAME_ERR; MISO_OE=0 throughout.
//  5. RST pulsed after bit 4 with SS held low:
//     - All outputs 0; no activity on further SCLK.
//     - SS high then low starts a clean frame.
//  6. SCLK half-period = SYNC_STAGES+3 CLK, random bytes x100:
//     - Every RX_DOUT and master-received byte matches the reference model.

Source files
------------

// File: rtl/spi_mode0_slave.sv
// spi_mode0_slave: SPI mode 0 (CPOL=0, CPHA=0) responder. It is full duplex and MSB first.
// SS, SCLK and MOSI are oversampled and edge-detected on CLK.
// Ports:
//   CLK, RST            system clock and synchronous active-high reset
//   SS, SCLK, MOSI      asynchronous SPI pins from the master (SS active low)
//   MISO, MISO_OE       registered serial output and its pad enable
//   TX_DIN / TX_ACK     next transmit byte; TX_ACK pulses after TX_DIN was captured
//   RX_DOUT / RX_VALID  last complete received byte; RX_VALID pulses when it updates
//   BUSY                frame active
//   FRAME_ERR           pulses when SS rises in the middle of a byte
module spi_mode0_slave #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SS,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [DATA_W-1:0] TX_DIN,
    output logic              TX_ACK,
    output logic [DATA_W-1:0] RX_DOUT,
    output logic              RX_VALID,
    output logic              BUSY,
    output logic              FRAME_ERR
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   ss_dly_q, ss_dly_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic [SYNC_STAGES:0]   fill_q, fill_d;
    logic                   armed_q, armed_d;
    logic [1:0]             state_q, state_d;
    logic [DATA_W-1:0]      tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]      rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   byte_done_q, byte_done_d;
    logic [DATA_W-1:0]      rx_dout_q, rx_dout_d;
    logic                   tx_ack_q, tx_ack_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   busy_q, busy_d;

    logic              ss_s_c, sclk_s_c, mosi_s_c;
    logic              ss_fall_c, ss_rise_c, sck_rise_c, sck_fall_c;
    logic              byte_end_c;
    logic [DATA_W-1:0] rx_byte_c;

    // Synchronizer taps and edge detection against a one-cycle delayed copy
    always_comb begin
        ss_s_c      = ss_sync_q[SYNC_STAGES-1];
        sclk_s_c    = sclk_sync_q[SYNC_STAGES-1];
        mosi_s_c    = mosi_sync_q[SYNC_STAGES-1];
        ss_fall_c   = ss_dly_q & ~ss_s_c;
        ss_rise_c   = ~ss_dly_q & ss_s_c;
        sck_rise_c  = ~sclk_dly_q & sclk_s_c;
        sck_fall_c  = sclk_dly_q & ~sclk_s_c;
        rx_byte_c   = {rx_sr_q[DATA_W-2:0], mosi_s_c};
        byte_end_c  = (state_q == ST_SHIFT) && sck_rise_c
                      && (bit_cnt_q == CNT_W'(DATA_W - 1));
    end

    // Next-state and output logic
    always_comb begin
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        ss_dly_d    = ss_s_c;
        sclk_dly_d  = sclk_s_c;
        fill_d      = {fill_q[SYNC_STAGES-1:0], 1'b1};
        // Armed only once SS is genuinely seen high after the chain holds real samples,
        // so an SS already low at reset release cannot start a frame.
        armed_d     = armed_q | (fill_q[SYNC_STAGES] & ss_s_c & ss_dly_q);
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        rx_dout_d   = rx_dout_q;
        tx_ack_d    = 1'b0;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (ss_rise_c) begin
            // SS release wins over any coincident SCLK edge, except a byte-completing rise
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            if (byte_end_c) begin
                rx_dout_d  = rx_byte_c;
                rx_valid_d = 1'b1;
            end else if (state_q == ST_SHIFT && bit_cnt_q != '0) begin
                frame_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall_c && armed_q) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    tx_sr_d     = TX_DIN;
                    tx_ack_d    = 1'b1;
                    bit_cnt_d   = '0;
                    byte_done_d = 1'b0;
                    state_d     = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sck_rise_c) begin
                        rx_sr_d = rx_byte_c;
                        if (byte_end_c) begin
                            rx_dout_d   = rx_byte_c;
                            rx_valid_d  = 1'b1;
                            bit_cnt_d   = '0;
                            byte_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (sck_fall_c) begin
                        // Falling edge after a full byte loads the next byte of the frame
                        if (byte_done_q) begin
                            tx_sr_d     = TX_DIN;
                            tx_ack_d    = 1'b1;
                            byte_done_d = 1'b0;
                        end else if (bit_cnt_q != '0) begin
                            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        miso_oe_d = (state_d == ST_SHIFT);
        busy_d    = (state_d != ST_IDLE);
        miso_d    = miso_oe_d & tx_sr_d[DATA_W-1];
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            ss_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_dly_q    <= 1'b1;
            sclk_dly_q  <= 1'b0;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
            rx_dout_q   <= '0;
            tx_ack_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_dly_q    <= ss_dly_d;
            sclk_dly_q  <= sclk_dly_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            rx_dout_q   <= rx_dout_d;
            tx_ack_q    <= tx_ack_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign MISO      = miso_q;
    assign MISO_OE   = miso_oe_q;
    assign TX_ACK    = tx_ack_q;
    assign RX_DOUT   = rx_dout_q;
    assign RX_VALID  = rx_valid_q;
    assign BUSY      = busy_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_spi_mode0_slave.sv
// Testbench for spi_mode0_slave: a mode 0 master model drives the pins, and monitors score
// RX_DOUT and the bytes the master reads back against queued expectations.
module tb_spi_mode0_slave;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned H           = SYNC_STAGES + 3;

    logic        CLK;
    logic        RST;
    logic        SS;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        MISO_OE;
    logic [7:0]  TX_DIN = '0;
    logic        TX_ACK;
    logic [7:0]  RX_DOUT;
    logic        RX_VALID;
    logic        BUSY;
    logic        FRAME_ERR;

    spi_mode0_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK(CLK), .RST(RST), .SS(SS), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .TX_DIN(TX_DIN), .TX_ACK(TX_ACK),
        .RX_DOUT(RX_DOUT), .RX_VALID(RX_VALID), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ack = 0, n_valid = 0, n_ferr = 0, n_oe = 0;
    int a0, v0, e0, o0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_miso_q[$];
    logic [7:0] tx_src[$];
    logic [7:0] mosi_q[$];
    logic [7:0] miso_byte;
    logic [7:0] discard;
    event       miso_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Pulse counters, TX_DIN supply and RX scoreboard, all sampled on the falling edge
    always @(negedge CLK) begin
        if (TX_ACK) n_ack++;
        if (RX_VALID) n_valid++;
        if (FRAME_ERR) n_ferr++;
        if (MISO_OE) n_oe++;
        if (TX_ACK && tx_src.size() != 0) discard = tx_src.pop_front();
        TX_DIN = (tx_src.size() != 0) ? tx_src[0] : 8'h00;
        if (RX_VALID) begin
            if (exp_rx_q.size() == 0) begin
                n_checks++;
                $display("FAIL rx_unexpected: got 0x%0h expected no RX_VALID", RX_DOUT);
            end else begin
                check("rx_dout", 32'(RX_DOUT), 32'(exp_rx_q.pop_front()));
            end
        end
    end

    // Master-received byte scoreboard
    always @(miso_ev) begin
        if (exp_miso_q.size() == 0) begin
            n_checks++;
            $display("FAIL miso_unexpected: got 0x%0h expected no byte", miso_byte);
        end else begin
            check("miso_byte", 32'(miso_byte), 32'(exp_miso_q.pop_front()));
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic snap();
        a0 = n_ack; v0 = n_valid; e0 = n_ferr; o0 = n_oe;
    endtask

    // One mode 0 bit; on the last bit of a frame SCLK returns low together with SS rising
    task automatic spi_bit(input logic mo, input logic last, output logic mi);
        MOSI = mo;
        wait_neg(H);
        mi   = MISO;
        SCLK = 1'b1;
        wait_neg(H);
        SCLK = 1'b0;
        if (last) SS = 1'b1;
    endtask

    task automatic spi_bits(input int nbits, input logic end_frame);
        logic [7:0] acc;
        logic [7:0] cur;
        logic       mi;
        acc = '0;
        SS  = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            cur = mosi_q[i / 8];
            spi_bit(cur[7 - (i % 8)], end_frame && (i == nbits - 1), mi);
            acc = {acc[6:0], mi};
            if (i % 8 == 7) begin
                miso_byte = acc;
                -> miso_ev;
            end
        end
        if (end_frame) wait_neg(2 * H);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        wait_neg(4);
        RST = 1'b0;
        wait_neg(10);
        check("reset_outputs",
              32'({MISO, MISO_OE, TX_ACK, RX_VALID, BUSY, FRAME_ERR, RX_DOUT}), 32'h0);

        // Single byte 0xA5 in, 0x3C out
        snap();
        mosi_q = {8'hA5}; tx_src.push_back(8'h3C);
        exp_rx_q.push_back(8'hA5); exp_miso_q.push_back(8'h3C);
        spi_bits(8, 1'b1);
        check("t1_tx_ack", 32'(n_ack - a0), 32'd1);
        check("t1_rx_valid", 32'(n_valid - v0), 32'd1);
        check("t1_frame_err", 32'(n_ferr - e0), 32'd0);
        check("t1_busy_after", 32'(BUSY), 32'd0);
        check("t1_rx_dout", 32'(RX_DOUT), 32'hA5);

        // Aborted frame after 3 bits, then a clean 0x5A frame
        snap();
        mosi_q = {8'hD0};
        spi_bits(3, 1'b1);
        check("t3_frame_err", 32'(n_ferr - e0), 32'd1);
        check("t3_rx_valid", 32'(n_valid - v0), 32'd0);
        check("t3_rx_dout_kept", 32'(RX_DOUT), 32'hA5);
        check("t3_miso_oe", 32'(MISO_OE), 32'd0);
        mosi_q = {8'h5A}; tx_src.push_back(8'hE7);
        exp_rx_q.push_back(8'h5A); exp_miso_q.push_back(8'hE7);
        spi_bits(8, 1'b1);
        check("t3_rx_dout_next", 32'(RX_DOUT), 32'h5A);
        check("t3_frame_err_once", 32'(n_ferr - e0), 32'd1);

        // Five-byte frame
        snap();
        mosi_q = {8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            tx_src.push_back(8'(8'h10 + i));
            exp_miso_q.push_back(8'(8'h10 + i));
            exp_rx_q.push_back(mosi_q[i]);
        end
        spi_bits(40, 1'b1);
        check("t2_tx_ack", 32'(n_ack - a0), 32'd5);
        check("t2_rx_valid", 32'(n_valid - v0), 32'd5);
        check("t2_frame_err", 32'(n_ferr - e0), 32'd0);

        // SCLK activity with SS high
        snap();
        for (int i = 0; i < 16; i++) begin
            MOSI = 1'(i);
            SCLK = ~SCLK;
            wait_neg(H);
        end
        wait_neg(H);
        check("t4_tx_ack", 32'(n_ack - a0), 32'd0);
        check("t4_rx_valid", 32'(n_valid - v0), 32'd0);
        check("t4_frame_err", 32'(n_ferr - e0), 32'd0);
        check("t4_miso_oe_cycles", 32'(n_oe - o0), 32'd0);

        // Reset in the middle of a frame with SS held low
        snap();
        mosi_q = {8'hC3}; tx_src.push_back(8'h77);
        spi_bits(4, 1'b0);
        check("t5_busy_mid", 32'(BUSY), 32'd1);
        check("t5_miso_oe_mid", 32'(MISO_OE), 32'd1);
        RST = 1'b1;
        wait_neg(2);
        RST = 1'b0;
        wait_neg(1);
        check("t5_reset_outputs",
              32'({MISO, MISO_OE, TX_ACK, RX_VALID, BUSY, FRAME_ERR, RX_DOUT}), 32'h0);
        o0 = n_oe;
        spi_bits(4, 1'b0);
        wait_neg(H);
        check("t5_tx_ack", 32'(n_ack - a0), 32'd1);
        check("t5_rx_valid", 32'(n_valid - v0), 32'd0);
        check("t5_frame_err", 32'(n_ferr - e0), 32'd0);
        check("t5_busy_idle", 32'(BUSY), 32'd0);
        check("t5_miso_oe_cycles", 32'(n_oe - o0), 32'd0);
        SS = 1'b1;
        wait_neg(2 * H);
        mosi_q = {8'h69}; tx_src.push_back(8'h96);
        exp_rx_q.push_back(8'h69); exp_miso_q.push_back(8'h96);
        spi_bits(8, 1'b1);
        check("t5_clean_rx_valid", 32'(n_valid - v0), 32'd1);
        check("t5_clean_rx_dout", 32'(RX_DOUT), 32'h69);

        // Random traffic at minimum SCLK half-period: 20 frames of 5 bytes
        snap();
        for (int f = 0; f < 20; f++) begin
            mosi_q.delete();
            for (int b = 0; b < 5; b++) begin
                logic [7:0] m, t;
                m = 8'($urandom_range(0, 255));
                t = 8'($urandom_range(0, 255));
                mosi_q.push_back(m);
                tx_src.push_back(t);
                exp_rx_q.push_back(m);
                exp_miso_q.push_back(t);
            end
            spi_bits(40, 1'b1);
        end
        check("t6_rx_valid", 32'(n_valid - v0), 32'd100);
        check("t6_tx_ack", 32'(n_ack - a0), 32'd100);
        check("t6_frame_err", 32'(n_ferr - e0), 32'd0);

        wait_neg(4);
        check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
        check("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
